sar_frame_packer: RTL and testbench
===================================

Name: sar_frame_packer

Overview:
Downstream stage of the SAR converter that feeds the UART transmitter. It captures each completed SAR conversion and buffers it in a small FIFO. It serialises each buffered sample into a 4-byte frame (header, high byte, low byte, XOR checksum) and drives the transmitter's start/end-of-transmission handshake one byte at a time. This replaces the direct truncated-result link, so all Width bits reach the host and back-to-back conversions are not lost while a frame is in flight.

Parameters:
Width, 10, SAR result width; legal range 9..16.
Depth, 4, FIFO entries; power of two, >= 2.
Header, 8'hA5, frame sync byte sent first in every frame.

Ports:
clk_i  input  1  system clock.
rst_i  input  1  reset; asynchronous, active-low.
sample_valid_i  input  1  one-cycle pulse; sample_i is valid (SAR end-of-conversion).
sample_i  input  Width  SAR conversion result.
eot_i  input  1  one-cycle pulse from the transmitter at the end of the stop bit.
clear_i  input  1  synchronous clear of overflow_o.
start_tx_o  output  1  one-cycle pulse; the transmitter loads tx_data_o.
tx_data_o  output  8  byte to transmit; stable from the start_tx_o pulse until the next start_tx_o pulse.
busy_o  output  1  high while a frame is in progress (FSM not in IDLE).
level_o  output  $clog2(Depth)+1  FIFO occupancy.
overflow_o  output  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst_i=0, asynchronous): FIFO empty; FSM in IDLE; byte index 0.
  - All outputs are 0: start_tx_o, tx_data_o, busy_o, level_o, overflow_o.
  - Reset mid-frame abandons the frame and discards FIFO contents. No partial frame resumes after reset.
- Frame for sample s:
  - B0 = Header.
  - B1 = s[Width-1:8], zero-extended to 8 bits.
  - B2 = s[7:0].
  - B3 = B0 ^ B1 ^ B2.
- FIFO push:
  - A push occurs on a clock edge with sample_valid_i=1, when level < Depth or a pop occurs on the same edge.
  - When the FIFO is full and no pop occurs, the sample is dropped, level is unchanged, and overflow_o is set on that edge.
  - overflow_o clears on an edge with clear_i=1, unless a drop happens on the same edge; the drop (set) wins.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if level > 0, pop the FIFO head into the frame register, set index=0, go to SEND. Otherwise stay in IDLE.
  - SEND (lasts 1 cycle): start_tx_o=1; tx_data_o is registered to B[index] on entry to SEND; go to WAIT.
  - WAIT: on eot_i=1, if index==3 go to IDLE; else index+1 and go to SEND. Without eot_i, stay in WAIT with no timeout.
- Latency:
  - sample_valid_i high in cycle k with FIFO empty and FSM idle → start_tx_o high in cycle k+2 with tx_data_o=Header.
  - eot_i in cycle m (index < 3) → start_tx_o in cycle m+1.
  - Final eot_i in cycle m with level > 0 → next frame's start_tx_o in cycle m+2.
- eot_i arriving in IDLE or SEND is ignored.
- start_tx_o is never asserted while the FSM is in WAIT. Exactly 4 start_tx_o pulses are issued per popped sample.
- tx_data_o holds its last value in IDLE.
- level_o reflects push/pop after each edge; a simultaneous push and pop leaves the level unchanged.

Test Plan:
- Single sample, Width=10: sample_i=10'h2C7 pulsed, transmitter model returns eot_i 20 cycles after each start → bytes A5, 02, C7, 60; first start_tx_o 2 cycles after valid; busy_o falls after the 4th eot_i; level_o returns to 0.
- Back-to-back samples 10'h3FF then 10'h000, 1 cycle apart → frames A5,03,FF,59 then A5,00,00,A5; no gap beyond 2 cycles between frames.
- Overflow: eot_i held low, 6 samples 1..6 pulsed → sample 1 in the frame register, level_o=4, sample 6 dropped, overflow_o=1. After releasing eot_i, frames for samples 1..5 only. clear_i clears overflow_o; clear_i asserted on the same edge as a drop → overflow_o stays 1.
- Full FIFO with push on the same edge as the IDLE pop → sample accepted, level_o stays 4, overflow_o stays 0.
- Spurious eot_i in IDLE and in SEND → no state change, no extra start_tx_o; the byte sequence is unchanged.
- rst_i low for 1 cycle (asynchronous, between clock edges) during WAIT of byte B2 → all outputs 0 immediately. A new sample after release → fresh frame starting with A5.

Source files
------------

// File: rtl/sar_frame_packer.sv
// SAR result packer: buffers conversions in a FIFO and sends each one
// to the UART as a 4-byte frame: header, high byte, low byte, XOR checksum.
// Ports: clk_i, rst_i (async, active-low), sample_valid_i/sample_i (SAR result),
// eot_i (end of byte from the transmitter), clear_i (clears overflow_o),
// start_tx_o/tx_data_o (byte handshake), busy_o, level_o, overflow_o.
module sar_frame_packer #(
  parameter int          Width  = 10,
  parameter int          Depth  = 4,
  parameter logic [7:0]  Header = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [Width-1:0]         sample_i,
  input  logic                     eot_i,
  input  logic                     clear_i,
  output logic                     start_tx_o,
  output logic [7:0]               tx_data_o,
  output logic                     busy_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t           state;
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [Width-1:0] frame;
  logic [1:0]       idx;
  logic             pop;
  logic             push;
  logic             drop;

  // A pop only happens from IDLE, so a full FIFO can still accept a
  // sample on the very edge the head moves into the frame register.
  assign pop  = (state == IDLE) && (level != '0);
  assign push = sample_valid_i && ((level != LW'(Depth)) || pop);
  assign drop = sample_valid_i && !push;

  assign busy_o  = (state != IDLE);
  assign level_o = level;

  function automatic logic [7:0] frame_byte(
    input logic [1:0]       i,
    input logic [Width-1:0] s
  );
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] b;
    hi = 8'(s >> 8);
    lo = s[7:0];
    b  = Header ^ hi ^ lo;
    case (i)
      2'd0:    b = Header;
      2'd1:    b = hi;
      2'd2:    b = lo;
      default: b = Header ^ hi ^ lo;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= sample_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      // a drop on the clearing edge keeps the flag set
      if (drop)         overflow_o <= 1'b1;
      else if (clear_i) overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      frame      <= '0;
      idx        <= '0;
      start_tx_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      start_tx_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            frame      <= mem[rd_ptr];
            idx        <= '0;
            tx_data_o  <= Header;
            start_tx_o <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (eot_i) begin
            if (idx == 2'd3) begin
              state <= IDLE;
            end else begin
              idx        <= idx + 2'd1;
              tx_data_o  <= frame_byte(idx + 2'd1, frame);
              start_tx_o <= 1'b1;
              state      <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_frame_packer.sv
// Testbench for sar_frame_packer: scoreboard of expected frame bytes,
// transmitter model returning eot_i a fixed delay after each start.
module tb_sar_frame_packer;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       sample_valid_i;
  logic [9:0] sample_i;
  logic       eot_i;
  logic       clear_i;
  logic       start_tx_o;
  logic [7:0] tx_data_o;
  logic       busy_o;
  logic [2:0] level_o;
  logic       overflow_o;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_start = 0;
  int n_eot = 0;
  int cnt = 0;
  int eot_delay = 20;
  bit eot_en = 1'b1;
  bit spur_eot = 1'b0;
  bit fire;
  int push_cyc;
  logic [7:0] mon_e;
  logic [7:0] exp_q[$];
  int start_cyc_q[$];
  int eot_cyc_q[$];

  sar_frame_packer #(
    .Width(10),
    .Depth(4),
    .Header(8'hA5)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .sample_valid_i(sample_valid_i),
    .sample_i(sample_i),
    .eot_i(eot_i),
    .clear_i(clear_i),
    .start_tx_o(start_tx_o),
    .tx_data_o(tx_data_o),
    .busy_o(busy_o),
    .level_o(level_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard: every start_tx_o pulse pops one expected byte
  initial forever begin
    @(negedge clk);
    if (rst_i === 1'b1 && start_tx_o === 1'b1) begin
      n_start++;
      start_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_start: got byte %h, none expected", tx_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (tx_data_o !== mon_e)
          $display("FAIL tx_byte: got %h expected %h", tx_data_o, mon_e);
        else
          passes++;
      end
    end
  end

  // transmitter model
  initial begin
    eot_i = 1'b0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (rst_i !== 1'b1) begin
        cnt = 0;
      end else begin
        if (cnt > 0 && eot_en) begin
          cnt--;
          if (cnt == 0) fire = 1'b1;
        end
        if (start_tx_o === 1'b1) cnt = eot_delay;
      end
      if (fire) begin
        n_eot++;
        eot_cyc_q.push_back(cyc);
      end
      eot_i = fire | spur_eot;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [9:0] s);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = {6'b0, s[9:8]};
    lo = s[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    exp_q.push_back(8'hA5 ^ hi ^ lo);
  endtask

  task automatic push_s(input logic [9:0] s);
    tick;
    sample_valid_i = 1'b1;
    sample_i = s;
    push_cyc = cyc;
    tick;
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick;
      if (exp_q.size() == 0 && !busy_o && level_o == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok)
      $display("FAIL %s_drain: %0d bytes left, busy %b level %0d expected 0",
               nm, exp_q.size(), busy_o, level_o);
    else
      passes++;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    sample_valid_i = 1'b0;
    sample_i = '0;
    clear_i = 1'b0;
    repeat (3) tick;
    checks++;
    if ({start_tx_o, tx_data_o, busy_o, level_o, overflow_o} !== 14'd0)
      $display("FAIL reset_outputs: got %b expected all 0",
               {start_tx_o, tx_data_o, busy_o, level_o, overflow_o});
    else
      passes++;
    rst_i = 1'b1;
    repeat (2) tick;
    checks++;
    if ({start_tx_o, tx_data_o, busy_o, level_o, overflow_o} !== 14'd0)
      $display("FAIL after_reset_idle: got %b expected all 0",
               {start_tx_o, tx_data_o, busy_o, level_o, overflow_o});
    else
      passes++;
  endtask

  task automatic test_single;
    int bs;
    int be;
    eot_en = 1'b1;
    eot_delay = 20;
    start_cyc_q.delete();
    eot_cyc_q.delete();
    bs = n_start;
    be = n_eot;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'hC7);
    exp_q.push_back(8'h60);
    push_s(10'h2C7);
    checks++;
    if (level_o !== 3'd1)
      $display("FAIL single_level: got %0d expected 1", level_o);
    else
      passes++;
    for (int i = 0; i < 10 && n_start < bs + 1; i++) tick;
    checks++;
    if (start_cyc_q.size() < 1 || start_cyc_q[0] - push_cyc != 2)
      $display("FAIL single_first_latency: got %0d expected 2",
               start_cyc_q.size() > 0 ? start_cyc_q[0] - push_cyc : -1);
    else
      passes++;
    for (int i = 0; i < 300 && n_eot < be + 4; i++) tick;
    checks++;
    if (n_start - bs != 4)
      $display("FAIL single_starts: got %0d expected 4", n_start - bs);
    else
      passes++;
    checks++;
    if (start_cyc_q.size() < 2 || eot_cyc_q.size() < 1 ||
        start_cyc_q[1] - eot_cyc_q[0] != 1)
      $display("FAIL single_eot_latency: got %0d expected 1",
               (start_cyc_q.size() > 1 && eot_cyc_q.size() > 0) ?
               start_cyc_q[1] - eot_cyc_q[0] : -1);
    else
      passes++;
    checks++;
    if (busy_o !== 1'b1)
      $display("FAIL single_busy_at_last_eot: got %b expected 1", busy_o);
    else
      passes++;
    tick;
    checks++;
    if (busy_o !== 1'b0 || level_o !== 3'd0)
      $display("FAIL single_idle: got busy %b level %0d expected 0 0",
               busy_o, level_o);
    else
      passes++;
    wait_drain("single");
  endtask

  task automatic test_back_to_back;
    int bs;
    int be;
    eot_delay = 4;
    start_cyc_q.delete();
    eot_cyc_q.delete();
    bs = n_start;
    be = n_eot;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h03);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h59);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hA5);
    tick;
    sample_valid_i = 1'b1;
    sample_i = 10'h3FF;
    tick;
    sample_i = 10'h000;
    tick;
    sample_valid_i = 1'b0;
    checks++;
    if (level_o !== 3'd1)
      $display("FAIL b2b_push_pop_level: got %0d expected 1", level_o);
    else
      passes++;
    for (int i = 0; i < 300 && n_eot < be + 8; i++) tick;
    checks++;
    if (start_cyc_q.size() < 5 || eot_cyc_q.size() < 4 ||
        start_cyc_q[4] - eot_cyc_q[3] != 2)
      $display("FAIL b2b_frame_gap: got %0d expected 2",
               (start_cyc_q.size() > 4 && eot_cyc_q.size() > 3) ?
               start_cyc_q[4] - eot_cyc_q[3] : -1);
    else
      passes++;
    checks++;
    if (n_start - bs != 8)
      $display("FAIL b2b_starts: got %0d expected 8", n_start - bs);
    else
      passes++;
    wait_drain("b2b");
  endtask

  task automatic test_spurious;
    int bs;
    eot_delay = 5;
    bs = n_start;
    tick;
    spur_eot = 1'b1;
    tick;
    spur_eot = 1'b0;
    repeat (3) tick;
    checks++;
    if (busy_o !== 1'b0 || n_start != bs)
      $display("FAIL spur_idle: got busy %b starts %0d expected 0 0",
               busy_o, n_start - bs);
    else
      passes++;
    push_frame(10'h1B4);
    tick;
    sample_valid_i = 1'b1;
    sample_i = 10'h1B4;
    @(posedge clk);
    #1;
    spur_eot = 1'b1;
    sample_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    spur_eot = 1'b0;
    tick;
    checks++;
    if (busy_o !== 1'b1 || n_start - bs != 1)
      $display("FAIL spur_send: got busy %b starts %0d expected 1 1",
               busy_o, n_start - bs);
    else
      passes++;
    wait_drain("spur");
    checks++;
    if (n_start - bs != 4)
      $display("FAIL spur_starts: got %0d expected 4", n_start - bs);
    else
      passes++;
  endtask

  task automatic test_overflow;
    int bs;
    eot_delay = 3;
    eot_en = 1'b0;
    bs = n_start;
    for (int s = 1; s <= 6; s++) begin
      if (s <= 5) push_frame(10'(s));
      push_s(10'(s));
    end
    tick;
    checks++;
    if (level_o !== 3'd4 || overflow_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL ovf_state: got level %0d ovf %b busy %b expected 4 1 1",
               level_o, overflow_o, busy_o);
    else
      passes++;
    checks++;
    if (n_start - bs != 1)
      $display("FAIL ovf_starts_held: got %0d expected 1", n_start - bs);
    else
      passes++;
    tick;
    sample_valid_i = 1'b1;
    sample_i = 10'd7;
    clear_i = 1'b1;
    tick;
    sample_valid_i = 1'b0;
    clear_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1 || level_o !== 3'd4)
      $display("FAIL ovf_clear_vs_drop: got ovf %b level %0d expected 1 4",
               overflow_o, level_o);
    else
      passes++;
    tick;
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0)
      $display("FAIL ovf_clear: got %b expected 0", overflow_o);
    else
      passes++;
  endtask

  task automatic test_full_pop;
    bit seen;
    seen = 1'b0;
    eot_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (!busy_o) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || level_o !== 3'd4)
      $display("FAIL fullpop_idle: got seen %b level %0d expected 1 4",
               seen, level_o);
    else
      passes++;
    push_frame(10'h2E9);
    sample_valid_i = 1'b1;
    sample_i = 10'h2E9;
    tick;
    sample_valid_i = 1'b0;
    checks++;
    if (level_o !== 3'd4 || overflow_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL fullpop_accept: got level %0d ovf %b busy %b expected 4 0 1",
               level_o, overflow_o, busy_o);
    else
      passes++;
    wait_drain("fullpop");
  endtask

  task automatic test_reset_mid;
    int bs;
    eot_delay = 10;
    bs = n_start;
    push_frame(10'h155);
    push_s(10'h155);
    for (int i = 0; i < 200 && n_start < bs + 3; i++) tick;
    push_s(10'h0AA);
    checks++;
    if (level_o !== 3'd1 || n_start - bs != 3)
      $display("FAIL rstmid_pre: got level %0d starts %0d expected 1 3",
               level_o, n_start - bs);
    else
      passes++;
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({start_tx_o, tx_data_o, busy_o, level_o, overflow_o} !== 14'd0)
      $display("FAIL rstmid_async: got %b expected all 0",
               {start_tx_o, tx_data_o, busy_o, level_o, overflow_o});
    else
      passes++;
    exp_q.delete();
    #9;
    rst_i = 1'b1;
    repeat (2) tick;
    checks++;
    if (busy_o !== 1'b0 || start_tx_o !== 1'b0 || level_o !== 3'd0)
      $display("FAIL rstmid_no_resume: got busy %b start %b level %0d expected 0 0 0",
               busy_o, start_tx_o, level_o);
    else
      passes++;
    bs = n_start;
    push_frame(10'h3C1);
    push_s(10'h3C1);
    wait_drain("rstmid");
    checks++;
    if (n_start - bs != 4)
      $display("FAIL rstmid_starts: got %0d expected 4", n_start - bs);
    else
      passes++;
  endtask

  initial begin
    rst_i = 1'b0;
    sample_valid_i = 1'b0;
    sample_i = '0;
    clear_i = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_spurious;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
